pomodoro_timer_core: RTL and testbench
======================================

Name: pomodoro_timer_core

Overview:
- Parametrised countdown engine for the Pomodoro timer; successor to the fixed 4-button, two-preset display timer.
- Provides N preset buttons with per-button durations, pause/resume, a timed alarm phase and BCD mm:ss digits.
- Sits between the debounced button inputs and the serial 7-segment driver (sclk/rclk/dio), which consumes the BCD outputs.

Parameters:
- COUNT_LIM, 50000000, clk cycles per second tick (must be ≥2).
- NUM_BTN, 4, number of preset buttons.
- T_WIDTH, 13, seconds-counter width (max 8191 s).
- PRESETS, {13'd60, 13'd300, 13'd600, 13'd1500}, packed NUM_BTN*T_WIDTH vector; slice i is the duration of btn[i] (btn[0]=1500, btn[3]=60 with defaults).
- ALARM_SEC, 3, alarm duration in seconds (≥1).
- BREAK_SEC, 300, break duration (used only with AUTO_CYCLE_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- btn  in  NUM_BTN  debounced preset buttons, level, active-high.
- pause_btn  in  1  debounced pause/resume button, level.
- remaining  out  T_WIDTH  seconds left.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD of remaining.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 ALARM.
- alarm  out  1  high while in ALARM.
- tick  out  1  one-cycle pulse per elapsed second while counting.
- phase  out  1  0 = work, 1 = break.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, remaining=0, alarm=0, tick=0, phase=0, prescaler=0, edge registers=0; all BCD digits read 0.
- Edge detect: btn and pause_btn are registered each cycle; a press is input=1 with registered value=0. A button held high fires once.
- Preset press (any state): on the edge where the press is detected, remaining ← PRESETS slice, prescaler ← 0, phase ← 0, state ← RUN, alarm ← 0. The new value is visible one cycle after the input is first sampled high.
- Simultaneous presets: the lowest index wins. A preset press overrides a pause press in the same cycle.
- A preset of 0 loads and enters ALARM directly.
- Prescaler counts 0..COUNT_LIM-1 in RUN and ALARM only. At COUNT_LIM-1 it wraps to 0 and tick=1 for that cycle.
- In PAUSE the prescaler and remaining are held, not cleared; the partial second is kept.
- RUN, on tick:
  - remaining > 1: decrement.
  - remaining == 1: remaining ← 0, state ← ALARM, alarm ← 1, alarm counter ← ALARM_SEC.
- pause_btn press: RUN→PAUSE, PAUSE→RUN. Ignored in IDLE and ALARM.
- ALARM: alarm counter decrements on tick. When it would reach 0, alarm ← 0 and state ← IDLE, unless AUTO_CYCLE_EN applies. remaining stays 0.
- BCD conversion:
  - min = remaining/60, sec = remaining%60, both combinational from the registered remaining.
  - min saturates at 99 for display only; remaining itself never saturates.
- No wrap-around: remaining never decrements below 0.
- rst mid-operation aborts any state immediately on that edge.

Optional Feature:
- Macro: POMODORO_AUTO_CYCLE_EN.
- Defined: when the alarm ends after a work phase (phase=0), remaining ← BREAK_SEC, phase ← 1, prescaler ← 0, state ← RUN. When the alarm ends after a break phase, go to IDLE with phase ← 0. A preset press during the break returns to the work phase.
- Undefined: the alarm always ends in IDLE; phase is tied to 0 and BREAK_SEC is unused.

Test Plan (COUNT_LIM=10, PRESETS={3,5,100,7}, ALARM_SEC=2, BREAK_SEC=4):
- Reset then btn[2]=1 held for 30 cycles → remaining=5 next cycle, a single load, state=RUN, tick every 10 cycles, remaining reaches 0 after 50 cycles, state=ALARM, alarm=1 for 20 cycles, then IDLE.
- btn[1] load (100) → digits 1:40 (min_ones=1, sec_tens=4, sec_ones=0); after one tick → 1:39.
- RUN with remaining=5, pause press mid-second, hold 37 cycles, press again → remaining frozen at 5 throughout, next tick lands exactly the remaining fraction of the second after resume.
- btn[0] and btn[3] rise in the same cycle during RUN → remaining=7; a preset pressed during ALARM → alarm=0, RUN with the new value.
- rst pulsed in RUN and in PAUSE → all outputs 0 and state=IDLE next cycle; a pause press in IDLE → no change.
- With POMODORO_AUTO_CYCLE_EN: a work phase of 5 s expires → 20-cycle alarm → remaining=4, phase=1, RUN → expiry → alarm → IDLE with phase=0.

Source files
------------

// File: rtl/pomodoro_timer_core.sv
`default_nettype none
// ============================================================================
// Module   : pomodoro_timer_core
// Brief    : Parametrised Pomodoro countdown engine. N preset buttons with
//            per-button durations, pause/resume, timed alarm phase and BCD
//            mm:ss digits for the serial 7-segment driver.
//            Optional macro POMODORO_AUTO_CYCLE_EN: after a work alarm the
//            engine starts a BREAK_SEC break automatically.
// Revision : 1.0 - initial release
// ============================================================================
module pomodoro_timer_core #(
    parameter int                         COUNT_LIM = 50000000,
    parameter int                         NUM_BTN   = 4,
    parameter int                         T_WIDTH   = 13,
    parameter logic [NUM_BTN*T_WIDTH-1:0] PRESETS   = {13'd60, 13'd300, 13'd600, 13'd1500},
    parameter int                         ALARM_SEC = 3,
    parameter int                         BREAK_SEC = 300
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               pause_btn,
    output logic [T_WIDTH-1:0] remaining,
    output logic [3:0]         min_tens,
    output logic [3:0]         min_ones,
    output logic [3:0]         sec_tens,
    output logic [3:0]         sec_ones,
    output logic [1:0]         state,
    output logic               alarm,
    output logic               tick,
    output logic               phase
);

    localparam int c_PW = (COUNT_LIM > 1) ? $clog2(COUNT_LIM) : 1;
    localparam int c_AW = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;

    localparam logic [c_PW-1:0] c_PRESC_MAX  = c_PW'(COUNT_LIM - 1);
    localparam logic [c_AW-1:0] c_ALARM_INIT = c_AW'(ALARM_SEC);

    localparam logic [1:0] c_ST_IDLE  = 2'b00;
    localparam logic [1:0] c_ST_RUN   = 2'b01;
    localparam logic [1:0] c_ST_PAUSE = 2'b10;
    localparam logic [1:0] c_ST_ALARM = 2'b11;

    // Reject parameter sets the counters cannot represent.
    generate
        if (COUNT_LIM < 2 || ALARM_SEC < 1 || BREAK_SEC < 0) begin : g_param_check
            $error("pomodoro_timer_core: invalid parameter value");
        end
    endgenerate

    logic [1:0]         r_state,     w_state_nxt;
    logic [T_WIDTH-1:0] r_remaining, w_remaining_nxt;
    logic [c_PW-1:0]    r_presc,     w_presc_nxt;
    logic [c_AW-1:0]    r_alarm_cnt, w_alarm_cnt_nxt;
    logic [NUM_BTN-1:0] r_btn_q;
    logic               r_pause_q;
`ifdef POMODORO_AUTO_CYCLE_EN
    logic               r_phase,     w_phase_nxt;
`endif

    logic [NUM_BTN-1:0] w_btn_press;
    logic               w_pause_press;
    logic               w_any_preset;
    logic [T_WIDTH-1:0] w_preset_val;
    logic               w_presc_wrap;
    logic               w_counting;
    logic               w_tick;

    // State, counters and button edge registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_remaining <= '0;
            r_presc     <= '0;
            r_alarm_cnt <= '0;
            r_btn_q     <= '0;
            r_pause_q   <= 1'b0;
`ifdef POMODORO_AUTO_CYCLE_EN
            r_phase     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_presc     <= w_presc_nxt;
            r_alarm_cnt <= w_alarm_cnt_nxt;
            r_btn_q     <= btn;
            r_pause_q   <= pause_btn;
`ifdef POMODORO_AUTO_CYCLE_EN
            r_phase     <= w_phase_nxt;
`endif
        end
    end

    // Press detection, preset priority, and next-state / counter logic.
    always_comb begin
        w_btn_press   = btn & ~r_btn_q;
        w_pause_press = pause_btn & ~r_pause_q;
        w_any_preset  = |w_btn_press;

        // Walk downward so the lowest pressed index is the last one written.
        w_preset_val = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (w_btn_press[i]) begin
                w_preset_val = PRESETS[i*T_WIDTH +: T_WIDTH];
            end
        end

        // A pause press in RUN freezes the prescaler on that same edge, so
        // the partial second survives the pause untouched.
        w_presc_wrap = (r_presc == c_PRESC_MAX);
        w_counting   = ((r_state == c_ST_RUN) && !w_pause_press) || (r_state == c_ST_ALARM);
        w_tick       = !w_any_preset && w_counting && w_presc_wrap;

        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_presc_nxt     = r_presc;
        w_alarm_cnt_nxt = r_alarm_cnt;
`ifdef POMODORO_AUTO_CYCLE_EN
        w_phase_nxt     = r_phase;
`endif

        if (w_any_preset) begin
            w_remaining_nxt = w_preset_val;
            w_presc_nxt     = '0;
            w_alarm_cnt_nxt = c_ALARM_INIT;
            w_state_nxt     = (w_preset_val == '0) ? c_ST_ALARM : c_ST_RUN;
`ifdef POMODORO_AUTO_CYCLE_EN
            w_phase_nxt     = 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_pause_press) begin
                        w_state_nxt = c_ST_PAUSE;
                    end else begin
                        w_presc_nxt = w_presc_wrap ? '0 : (r_presc + c_PW'(1));
                        if (w_presc_wrap) begin
                            if (r_remaining > T_WIDTH'(1)) begin
                                w_remaining_nxt = r_remaining - T_WIDTH'(1);
                            end else begin
                                w_remaining_nxt = '0;
                                w_state_nxt     = c_ST_ALARM;
                                w_alarm_cnt_nxt = c_ALARM_INIT;
                            end
                        end
                    end
                end
                c_ST_PAUSE: begin
                    if (w_pause_press) begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
                c_ST_ALARM: begin
                    w_presc_nxt = w_presc_wrap ? '0 : (r_presc + c_PW'(1));
                    if (w_presc_wrap) begin
                        if (r_alarm_cnt > c_AW'(1)) begin
                            w_alarm_cnt_nxt = r_alarm_cnt - c_AW'(1);
                        end else begin
                            w_alarm_cnt_nxt = '0;
`ifdef POMODORO_AUTO_CYCLE_EN
                            if (!r_phase) begin
                                w_remaining_nxt = T_WIDTH'(BREAK_SEC);
                                w_phase_nxt     = 1'b1;
                                w_presc_nxt     = '0;
                                w_state_nxt     = c_ST_RUN;
                            end else begin
                                w_phase_nxt     = 1'b0;
                                w_state_nxt     = c_ST_IDLE;
                            end
`else
                            w_state_nxt = c_ST_IDLE;
`endif
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    logic [31:0] w_rem_ext;
    logic [31:0] w_min_raw;
    logic [6:0]  w_min_sat;
    logic [5:0]  w_sec;

    // mm:ss BCD split of the registered seconds; minutes clamp at 99 on display.
    always_comb begin
        w_rem_ext = 32'(r_remaining);
        w_min_raw = w_rem_ext / 32'd60;
        w_sec     = 6'(w_rem_ext % 32'd60);
        w_min_sat = (w_min_raw > 32'd99) ? 7'd99 : 7'(w_min_raw);
        min_tens  = 4'(w_min_sat / 7'd10);
        min_ones  = 4'(w_min_sat % 7'd10);
        sec_tens  = 4'(w_sec / 6'd10);
        sec_ones  = 4'(w_sec % 6'd10);
    end

    assign remaining = r_remaining;
    assign state     = r_state;
    assign alarm     = (r_state == c_ST_ALARM);
    assign tick      = w_tick;
`ifdef POMODORO_AUTO_CYCLE_EN
    assign phase     = r_phase;
`else
    assign phase     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pomodoro_timer_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_pomodoro_timer_core
// Brief    : Directed self-checking bench for pomodoro_timer_core with
//            COUNT_LIM=10, PRESETS={3,5,100,7}, ALARM_SEC=2, BREAK_SEC=4.
//            A second instance covers minute saturation and the zero preset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pomodoro_timer_core;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_ALARM = 2'b11;

    logic        clk;
    logic        rst;
    logic [3:0]  btn;
    logic        pause_btn;
    logic [12:0] remaining;
    logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0]  state;
    logic        alarm, tick, phase;

    logic [1:0]  btn_b;
    logic        pause_b;
    logic [12:0] remaining_b;
    logic [3:0]  min_tens_b, min_ones_b, sec_tens_b, sec_ones_b;
    logic [1:0]  state_b;
    logic        alarm_b, tick_b, phase_b;

    int n_cmp  = 0;
    int n_fail = 0;

    pomodoro_timer_core #(
        .COUNT_LIM (10),
        .NUM_BTN   (4),
        .T_WIDTH   (13),
        .PRESETS   ({13'd3, 13'd5, 13'd100, 13'd7}),
        .ALARM_SEC (2),
        .BREAK_SEC (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .pause_btn (pause_btn),
        .remaining (remaining),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .state     (state),
        .alarm     (alarm),
        .tick      (tick),
        .phase     (phase)
    );

    pomodoro_timer_core #(
        .COUNT_LIM (10),
        .NUM_BTN   (2),
        .T_WIDTH   (13),
        .PRESETS   ({13'd0, 13'd6000}),
        .ALARM_SEC (2),
        .BREAK_SEC (4)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn_b),
        .pause_btn (pause_b),
        .remaining (remaining_b),
        .min_tens  (min_tens_b),
        .min_ones  (min_ones_b),
        .sec_tens  (sec_tens_b),
        .sec_ones  (sec_ones_b),
        .state     (state_b),
        .alarm     (alarm_b),
        .tick      (tick_b),
        .phase     (phase_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case something stalls the sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; btn = '0; pause_btn = 1'b0; btn_b = '0; pause_b = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = '0; pause_btn = 1'b0; btn_b = '0; pause_b = 1'b0;
        step(); step();
        rst = 1'b0;
        n_cmp++; if (state !== ST_IDLE) begin $display("FAIL reset_state: got %b want %b", state, ST_IDLE); n_fail++; end
        n_cmp++; if (remaining !== 13'd0) begin $display("FAIL reset_remaining: got %0d want 0", remaining); n_fail++; end
        n_cmp++; if ({alarm, tick, phase} !== 3'b000) begin $display("FAIL reset_flags: got %b want 000", {alarm, tick, phase}); n_fail++; end
        n_cmp++; if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000) begin $display("FAIL reset_digits: got %h want 0000", {min_tens, min_ones, sec_tens, sec_ones}); n_fail++; end
        n_cmp++; if (state_b !== ST_IDLE) begin $display("FAIL reset_state_b: got %b want %b", state_b, ST_IDLE); n_fail++; end
    endtask

    // btn[2] (5 s) held for 30 cycles: one load, countdown, 20-cycle alarm.
    task automatic test_basic();
        logic [1:0]  exp_st;
        logic [12:0] exp_rem;
        logic        exp_tick;
        do_reset();
        btn = 4'b0100;
        step();
        n_cmp++; if (remaining !== 13'd5) begin $display("FAIL basic_load_rem: got %0d want 5", remaining); n_fail++; end
        n_cmp++; if (state !== ST_RUN) begin $display("FAIL basic_load_state: got %b want %b", state, ST_RUN); n_fail++; end
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k < 50) begin
                exp_st = ST_RUN; exp_rem = 13'(5 - k / 10);
            end else if (k < 70) begin
                exp_st = ST_ALARM; exp_rem = 13'd0;
            end else begin
`ifdef POMODORO_AUTO_CYCLE_EN
                exp_st = ST_RUN; exp_rem = 13'd4;
`else
                exp_st = ST_IDLE; exp_rem = 13'd0;
`endif
            end
            exp_tick = ((k % 10) == 9) && (k < 70);
            n_cmp++; if (state !== exp_st) begin $display("FAIL basic_state k=%0d: got %b want %b", k, state, exp_st); n_fail++; end
            n_cmp++; if (remaining !== exp_rem) begin $display("FAIL basic_rem k=%0d: got %0d want %0d", k, remaining, exp_rem); n_fail++; end
            n_cmp++; if (tick !== exp_tick) begin $display("FAIL basic_tick k=%0d: got %b want %b", k, tick, exp_tick); n_fail++; end
            n_cmp++; if (alarm !== (exp_st == ST_ALARM)) begin $display("FAIL basic_alarm k=%0d: got %b want %b", k, alarm, exp_st == ST_ALARM); n_fail++; end
            if (k == 30) btn = '0;
        end
    endtask

    task automatic test_bcd();
        do_reset();
        btn = 4'b0010;
        step();
        btn = '0;
        n_cmp++; if (remaining !== 13'd100) begin $display("FAIL bcd_load_rem: got %0d want 100", remaining); n_fail++; end
        n_cmp++; if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0140) begin $display("FAIL bcd_1m40: got %h want 0140", {min_tens, min_ones, sec_tens, sec_ones}); n_fail++; end
        repeat (10) step();
        n_cmp++; if (remaining !== 13'd99) begin $display("FAIL bcd_tick_rem: got %0d want 99", remaining); n_fail++; end
        n_cmp++; if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0139) begin $display("FAIL bcd_1m39: got %h want 0139", {min_tens, min_ones, sec_tens, sec_ones}); n_fail++; end
    endtask

    // Pause 4 cycles into the first second; the remaining 5 cycles resume after.
    task automatic test_pause();
        do_reset();
        btn = 4'b0100;
        step();
        btn = '0;
        repeat (4) step();
        pause_btn = 1'b1;
        step();
        n_cmp++; if (state !== ST_PAUSE) begin $display("FAIL pause_enter: got %b want %b", state, ST_PAUSE); n_fail++; end
        for (int i = 1; i <= 37; i++) begin
            step();
            n_cmp++; if (state !== ST_PAUSE) begin $display("FAIL pause_hold_state i=%0d: got %b want %b", i, state, ST_PAUSE); n_fail++; end
            n_cmp++; if (remaining !== 13'd5) begin $display("FAIL pause_hold_rem i=%0d: got %0d want 5", i, remaining); n_fail++; end
            n_cmp++; if (tick !== 1'b0) begin $display("FAIL pause_hold_tick i=%0d: got %b want 0", i, tick); n_fail++; end
            if (i == 2) pause_btn = 1'b0;
        end
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        n_cmp++; if (state !== ST_RUN) begin $display("FAIL pause_resume: got %b want %b", state, ST_RUN); n_fail++; end
        for (int j = 1; j <= 6; j++) begin
            step();
            n_cmp++; if (tick !== (j == 5)) begin $display("FAIL resume_tick j=%0d: got %b want %b", j, tick, j == 5); n_fail++; end
            n_cmp++; if (remaining !== ((j < 6) ? 13'd5 : 13'd4)) begin $display("FAIL resume_rem j=%0d: got %0d want %0d", j, remaining, (j < 6) ? 5 : 4); n_fail++; end
        end
    endtask

    // Runs straight on from test_pause (RUN, remaining=4).
    task automatic test_priority();
        bit reached;
        btn = 4'b1001;
        step();
        btn = '0;
        n_cmp++; if (remaining !== 13'd7) begin $display("FAIL prio_lowest: got %0d want 7", remaining); n_fail++; end
        step();
        btn = 4'b1000; pause_btn = 1'b1;
        step();
        btn = '0; pause_btn = 1'b0;
        n_cmp++; if (remaining !== 13'd3) begin $display("FAIL prio_preset_rem: got %0d want 3", remaining); n_fail++; end
        n_cmp++; if (state !== ST_RUN) begin $display("FAIL prio_over_pause: got %b want %b", state, ST_RUN); n_fail++; end
        reached = 1'b0;
        for (int i = 0; i < 60 && !reached; i++) begin
            step();
            if (state === ST_ALARM) reached = 1'b1;
        end
        n_cmp++; if (!reached) begin $display("FAIL prio_alarm_wait: state %b, ALARM not reached in 60 cycles", state); n_fail++; end
        step();
        btn = 4'b0010;
        step();
        btn = '0;
        n_cmp++; if (alarm !== 1'b0) begin $display("FAIL alarm_preset_alarm: got %b want 0", alarm); n_fail++; end
        n_cmp++; if (state !== ST_RUN) begin $display("FAIL alarm_preset_state: got %b want %b", state, ST_RUN); n_fail++; end
        n_cmp++; if (remaining !== 13'd100) begin $display("FAIL alarm_preset_rem: got %0d want 100", remaining); n_fail++; end
    endtask

    // Runs straight on from test_priority (RUN, remaining=100).
    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (state !== ST_IDLE) begin $display("FAIL rst_run_state: got %b want %b", state, ST_IDLE); n_fail++; end
        n_cmp++; if ({remaining, alarm, tick, phase} !== 16'h0000) begin $display("FAIL rst_run_outputs: got %h want 0000", {remaining, alarm, tick, phase}); n_fail++; end
        n_cmp++; if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000) begin $display("FAIL rst_run_digits: got %h want 0000", {min_tens, min_ones, sec_tens, sec_ones}); n_fail++; end
        btn = 4'b0100;
        step();
        btn = '0;
        step();
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        n_cmp++; if (state !== ST_PAUSE) begin $display("FAIL rst_pause_setup: got %b want %b", state, ST_PAUSE); n_fail++; end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (state !== ST_IDLE) begin $display("FAIL rst_pause_state: got %b want %b", state, ST_IDLE); n_fail++; end
        n_cmp++; if (remaining !== 13'd0) begin $display("FAIL rst_pause_rem: got %0d want 0", remaining); n_fail++; end
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        n_cmp++; if (state !== ST_IDLE) begin $display("FAIL idle_pause_state: got %b want %b", state, ST_IDLE); n_fail++; end
        n_cmp++; if (remaining !== 13'd0) begin $display("FAIL idle_pause_rem: got %0d want 0", remaining); n_fail++; end
    endtask

    // Second instance: 6000 s shows 99:00, a zero preset goes straight to ALARM.
    task automatic test_sat_zero();
        do_reset();
        btn_b = 2'b01;
        step();
        btn_b = '0;
        n_cmp++; if (remaining_b !== 13'd6000) begin $display("FAIL sat_rem: got %0d want 6000", remaining_b); n_fail++; end
        n_cmp++; if ({min_tens_b, min_ones_b, sec_tens_b, sec_ones_b} !== 16'h9900) begin $display("FAIL sat_digits: got %h want 9900", {min_tens_b, min_ones_b, sec_tens_b, sec_ones_b}); n_fail++; end
        step();
        btn_b = 2'b10;
        step();
        btn_b = '0;
        n_cmp++; if (state_b !== ST_ALARM) begin $display("FAIL zero_state: got %b want %b", state_b, ST_ALARM); n_fail++; end
        n_cmp++; if ({remaining_b, alarm_b} !== 14'h0001) begin $display("FAIL zero_rem_alarm: got %h want 0001", {remaining_b, alarm_b}); n_fail++; end
        repeat (19) step();
        n_cmp++; if (state_b !== ST_ALARM) begin $display("FAIL zero_alarm_len: got %b want %b", state_b, ST_ALARM); n_fail++; end
        step();
`ifdef POMODORO_AUTO_CYCLE_EN
        n_cmp++; if ({state_b, remaining_b} !== {ST_RUN, 13'd4}) begin $display("FAIL zero_alarm_end: got %h want %h", {state_b, remaining_b}, {ST_RUN, 13'd4}); n_fail++; end
`else
        n_cmp++; if (state_b !== ST_IDLE) begin $display("FAIL zero_alarm_end: got %b want %b", state_b, ST_IDLE); n_fail++; end
`endif
    endtask

`ifdef POMODORO_AUTO_CYCLE_EN
    task automatic test_auto();
        do_reset();
        btn = 4'b0100;
        step();
        btn = '0;
        for (int k = 1; k <= 130; k++) begin
            step();
            case (k)
                49:  begin n_cmp++; if ({state, remaining, phase} !== {ST_RUN, 13'd1, 1'b0}) begin $display("FAIL auto_k49: got %h", {state, remaining, phase}); n_fail++; end end
                50:  begin n_cmp++; if ({state, remaining, phase} !== {ST_ALARM, 13'd0, 1'b0}) begin $display("FAIL auto_k50: got %h", {state, remaining, phase}); n_fail++; end end
                70:  begin n_cmp++; if ({state, remaining, phase} !== {ST_RUN, 13'd4, 1'b1}) begin $display("FAIL auto_break: got %h", {state, remaining, phase}); n_fail++; end end
                109: begin n_cmp++; if ({state, remaining, phase} !== {ST_RUN, 13'd1, 1'b1}) begin $display("FAIL auto_k109: got %h", {state, remaining, phase}); n_fail++; end end
                110: begin n_cmp++; if ({state, remaining, phase} !== {ST_ALARM, 13'd0, 1'b1}) begin $display("FAIL auto_k110: got %h", {state, remaining, phase}); n_fail++; end end
                129: begin n_cmp++; if (state !== ST_ALARM) begin $display("FAIL auto_k129: got %b want %b", state, ST_ALARM); n_fail++; end end
                130: begin n_cmp++; if ({state, remaining, phase} !== {ST_IDLE, 13'd0, 1'b0}) begin $display("FAIL auto_idle: got %h", {state, remaining, phase}); n_fail++; end end
                default: ;
            endcase
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bcd();
        test_pause();
        test_priority();
        test_reset_mid();
        test_sat_zero();
`ifdef POMODORO_AUTO_CYCLE_EN
        test_auto();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
